inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_W, default 6, byte-address width of program memory and program counter.
REQ-002 Parameter NOP_INST, default 32'h00000000, instruction word driven while no valid instruction is held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_master_n  input  1  reset, asynchronous assert, active-low.
REQ-005 add_i  input  ADDR_W  byte address of the requested instruction, driven by the program counter.
REQ-006 mem_addr  output  ADDR_W  byte address to program memory.
REQ-007 mem_rd  output  1  read strobe to program memory.
REQ-008 mem_data  input  8  program memory read data, valid exactly one cycle after the mem_rd cycle.
REQ-009 inst  output  32  assembled instruction word.
REQ-010 inst_valid  output  1  inst holds the instruction at fetched address.
REQ-011 stall  output  1  fetch in progress; program counter holds while high.

Function
REQ-012 Internal FSM SHALL have states IDLE, FETCH, DRAIN, VALID.
REQ-013 IDLE: on next edge SHALL latch base=add_i, clear byte count, go to FETCH.
REQ-014 FETCH: mem_rd=1, mem_addr=base+cnt, cnt 0..3, one byte request per cycle; after cnt=3 go to DRAIN.
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_W (base 62 reads 62,63,0,1).
REQ-016 Byte returned for request k SHALL be captured one cycle later into inst bits [31-8k:24-8k] (big-endian, first byte = opcode).
REQ-017 DRAIN: mem_rd=0, captures byte 3, go to VALID.
REQ-018 VALID: inst_valid=1, inst=assembled word, stall=0, mem_rd=0; stays while add_i==base.
REQ-019 inst_valid SHALL rise on the 6th rising edge after add_i is sampled in IDLE or VALID (1 latch + 4 FETCH + 1 DRAIN); stall high for those 6 cycles.
REQ-020 In VALID, add_i!=base SHALL on the same edge drop inst_valid, raise stall, latch new base, and enter FETCH with cnt=0.
REQ-021 add_i change during FETCH or DRAIN SHALL abort: partial bytes discarded, new base latched, FETCH restarts at cnt=0 next cycle; a data byte returning for an aborted request SHALL NOT be written.
REQ-022 add_i equal to base during FETCH/DRAIN SHALL NOT restart the fetch.
REQ-023 While inst_valid=0, inst SHALL equal NOP_INST; assembly register not visible.
REQ-024 stall SHALL equal NOT inst_valid at all times.
REQ-025 mem_addr SHALL equal base when mem_rd=0.

Reset
REQ-026 rst_master_n low SHALL immediately force state IDLE, inst_valid=0, stall=1, mem_rd=0, mem_addr=0, inst=NOP_INST, base=0, cnt=0, assembly register=0.
REQ-027 Reset asserted mid-FETCH SHALL discard all bytes; first fetch after deassert starts from current add_i in IDLE.
REQ-028 Deassertion SHALL be recognised on the first rising edge with rst_master_n high; no synchronizer internal to block.

Verification
REQ-029 Memory bytes 0..3 = 10,00,05,00, add_i=0, release reset -> mem_rd high 4 cycles with addr 0,1,2,3; inst=32'h10000500, inst_valid=1 on 6th edge; inst=0 before.
REQ-030 Hold add_i=0 for 10 cycles after valid -> inst stable 32'h10000500, mem_rd never asserted, stall=0.
REQ-031 add_i 0->4 while VALID, bytes 4..7 = 10,01,02,00 -> inst_valid drops same edge, inst=32'h10010200 valid 6 edges later.
REQ-032 add_i=62, bytes 62,63,0,1 = 21,3c,10,00 -> mem_addr sequence 62,63,0,1; inst=32'h213c1000.
REQ-033 add_i 8->12 after 2 FETCH cycles -> mem_addr restarts at 12; inst equals bytes 12..15 only; no byte from 8/9 appears.
REQ-034 rst_master_n pulsed low for 3 ns mid-FETCH (between edges) -> outputs reset immediately without clock; refetch completes normally.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Byte-wide program memory port between the fetch unit and its memory.
interface inst_fetch_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles a big-endian 32-bit word from four byte reads
// of program memory and holds it valid until the requested address changes.
//
// state | meaning
// IDLE  | out of reset; latch add_i as base on next edge
// FETCH | issue byte read base+cnt, capture byte cnt-1 returning this cycle
// DRAIN | no read issued; capture last byte
// VALID | word assembled and presented; watch add_i for a new address
module inst_fetch #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_master_n,
  input  logic [ADDR_W-1:0] add_i,
  inst_fetch_if.master      mem,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base, base_next;
  logic [1:0]        cnt, cnt_next;
  logic [31:0]       asm_q, asm_next;

  always_ff @(posedge clk or negedge rst_master_n) begin
    if (!rst_master_n) begin
      state <= IDLE;
      base  <= '0;
      cnt   <= '0;
      asm_q <= '0;
    end else begin
      state <= state_next;
      base  <= base_next;
      cnt   <= cnt_next;
      asm_q <= asm_next;
    end
  end

  always_comb begin
    state_next = state;
    base_next  = base;
    cnt_next   = cnt;
    asm_next   = asm_q;
    case (state)
      IDLE: begin
        base_next  = add_i;
        cnt_next   = '0;
        asm_next   = '0;
        state_next = FETCH;
      end
      FETCH: begin
        if (add_i != base) begin
          base_next  = add_i;
          cnt_next   = '0;
          asm_next   = '0;
          state_next = FETCH;
        end else begin
          // byte for the previous request arrives now; cnt==0 has none
          case (cnt)
            2'd1:    asm_next[31:24] = mem.mem_data;
            2'd2:    asm_next[23:16] = mem.mem_data;
            2'd3:    asm_next[15:8]  = mem.mem_data;
            default: asm_next        = asm_q;
          endcase
          if (cnt == 2'd3) begin
            state_next = DRAIN;
          end else begin
            cnt_next = cnt + 2'd1;
          end
        end
      end
      DRAIN: begin
        if (add_i != base) begin
          base_next  = add_i;
          cnt_next   = '0;
          asm_next   = '0;
          state_next = FETCH;
        end else begin
          asm_next[7:0] = mem.mem_data;
          cnt_next      = '0;
          state_next    = VALID;
        end
      end
      VALID: begin
        if (add_i != base) begin
          base_next  = add_i;
          cnt_next   = '0;
          asm_next   = '0;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_rd   = (state == FETCH);
    mem.mem_addr = (state == FETCH) ? base + ADDR_W'(cnt) : base;
    inst_valid   = (state == VALID);
    stall        = ~inst_valid;
    inst         = inst_valid ? asm_q : NOP_INST;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle-latency byte memory model.
module tb_inst_fetch;
  localparam int          AW  = 6;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk;
  logic          rst_master_n;
  logic [AW-1:0] add_i;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          stall;

  inst_fetch_if #(.ADDR_W(AW)) mbus ();

  inst_fetch #(.ADDR_W(AW), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst_master_n (rst_master_n),
    .add_i        (add_i),
    .mem          (mbus),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .stall        (stall)
  );

  logic [7:0] mem [0:63];
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data for a read strobe appears during the following cycle
  always @(posedge clk) begin
    if (mbus.mem_rd) mbus.mem_data <= mem[mbus.mem_addr];
    else             mbus.mem_data <= 8'hee;
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [31:0]   word;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] base, input logic [31:0] w);
    logic [AW-1:0] a;
    a = base;
    mem[a] = w[31:24]; a = a + 6'd1;
    mem[a] = w[23:16]; a = a + 6'd1;
    mem[a] = w[15:8];  a = a + 6'd1;
    mem[a] = w[7:0];
  endtask

  // six edges after add_i is sampled: 4 reads, drain, then valid word
  task automatic check_seq(input logic [AW-1:0] base, input logic [31:0] word, input string tag);
    logic [AW-1:0] a;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k <= 4) begin
        a = base + AW'(k - 1);
        chk({tag, " mem_rd"}, {31'd0, mbus.mem_rd}, 32'd1);
        chk({tag, " mem_addr"}, {26'd0, mbus.mem_addr}, {26'd0, a});
      end else begin
        chk({tag, " mem_rd idle"}, {31'd0, mbus.mem_rd}, 32'd0);
        chk({tag, " mem_addr idle"}, {26'd0, mbus.mem_addr}, {26'd0, base});
      end
      if (k < 6) begin
        chk({tag, " inst_valid low"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, " inst nop"}, inst, NOP);
        chk({tag, " stall high"}, {31'd0, stall}, 32'd1);
      end else begin
        chk({tag, " inst_valid high"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, " inst word"}, inst, word);
        chk({tag, " stall low"}, {31'd0, stall}, 32'd0);
      end
    end
  endtask

  task automatic do_fetch(input logic [AW-1:0] base, input logic [31:0] word, input string tag);
    load(base, word);
    add_i = base;
    check_seq(base, word, tag);
  endtask

  initial begin
    vec_t vecs [4];
    vecs[0] = '{base: 6'd4,  word: 32'h10010200};
    vecs[1] = '{base: 6'd62, word: 32'h213c1000};
    vecs[2] = '{base: 6'd20, word: 32'hdeadbeef};
    vecs[3] = '{base: 6'd40, word: 32'ha55a00ff};

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst_master_n = 1'b0;
    add_i        = '0;
    load(6'd0, 32'h10000500);
    #1;
    chk("reset inst", inst, NOP);
    chk("reset inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd1);
    chk("reset mem_rd", {31'd0, mbus.mem_rd}, 32'd0);
    chk("reset mem_addr", {26'd0, mbus.mem_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_master_n = 1'b1;
    check_seq(6'd0, 32'h10000500, "first");

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold inst", inst, 32'h10000500);
      chk("hold mem_rd", {31'd0, mbus.mem_rd}, 32'd0);
      chk("hold stall", {31'd0, stall}, 32'd0);
    end

    for (int v = 0; v < 4; v++) do_fetch(vecs[v].base, vecs[v].word, $sformatf("vec%0d", v));

    // abort: move from 8 to 12 after two fetch cycles
    load(6'd8, 32'h11223344);
    load(6'd12, 32'h55667788);
    add_i = 6'd8;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort pre mem_addr", {26'd0, mbus.mem_addr}, 32'd8 + 32'(k));
      chk("abort pre inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    add_i = 6'd12;
    check_seq(6'd12, 32'h55667788, "abort");

    // async reset pulse between edges in the middle of a fetch
    add_i = 6'd20;
    repeat (2) @(posedge clk);
    #2 rst_master_n = 1'b0;
    #1;
    chk("midrst inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst stall", {31'd0, stall}, 32'd1);
    chk("midrst mem_rd", {31'd0, mbus.mem_rd}, 32'd0);
    chk("midrst mem_addr", {26'd0, mbus.mem_addr}, 32'd0);
    chk("midrst inst", inst, NOP);
    #2 rst_master_n = 1'b1;
    check_seq(6'd20, 32'hdeadbeef, "refetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
